// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline control unit: exception codes,
// stall vectors and the stall watchdog state encoding.
package pipe_ctrl_pkg;

    localparam logic [31:0] EXC_NONE         = 32'h0000_0000;
    localparam logic [31:0] EXC_INT          = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL      = 32'h0000_0008;
    localparam logic [31:0] EXC_INST_INVALID = 32'h0000_000a;
    localparam logic [31:0] EXC_OV           = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP         = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET         = 32'h0000_000e;

    // bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    typedef enum logic [1:0] {
        WD_IDLE    = 2'd0,
        WD_COUNT   = 2'd1,
        WD_EXPIRED = 2'd2
    } wd_state_t;

endpackage

// File: rtl/pipe_ctrl_watchdog.sv
// Stall watchdog: counts consecutive stalled cycles and emits a single
// registered pulse when the run length reaches TIMEOUT_CYCLES.
import pipe_ctrl_pkg::*;

module stall_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic req_any,
    input  logic clear,
    output logic timeout
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES);

    wd_state_t   state;
    wd_state_t   state_nxt;
    logic [15:0] count;
    logic [15:0] count_nxt;
    logic        pulse_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= WD_IDLE;
            count   <= '0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            timeout <= pulse_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        pulse_nxt = 1'b0;
        if (!req_any || clear) begin
            state_nxt = WD_IDLE;
            count_nxt = '0;
        end else begin
            unique case (state)
                WD_IDLE: begin
                    state_nxt = WD_COUNT;
                    count_nxt = 16'd1;
                end
                WD_COUNT: begin
                    count_nxt = count + 16'd1;
                    if (count_nxt == LIMIT) begin
                        state_nxt = WD_EXPIRED;
                        pulse_nxt = 1'b1;
                    end
                end
                WD_EXPIRED: begin
                    // counter frozen until the stall run ends
                    count_nxt = count;
                end
                default: begin
                    state_nxt = WD_IDLE;
                    count_nxt = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall merge, exception flush/redirect, stall watchdog.
// Optional stall/flush performance counters under PIPE_PERF_CNT_EN.
import pipe_ctrl_pkg::*;

module pipe_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] EXC_VECTOR     = 32'h0000_0020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_from_if,
    input  logic        stallreq_from_id,
    input  logic        stallreq_from_ex,
    input  logic        stallreq_from_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        stall_timeout_o,
`ifdef PIPE_PERF_CNT_EN
    output logic [31:0] stall_cycles_o,
    output logic [15:0] flush_count_o,
`endif
    output logic [31:0] last_excepttype_o
);

    logic req_any;

    assign req_any = stallreq_from_if | stallreq_from_id |
                     stallreq_from_ex | stallreq_from_mem;

    always_comb begin
        stall  = STALL_NONE;
        flush  = 1'b0;
        new_pc = '0;
        if (!rst) begin
            if (excepttype_i != EXC_NONE) begin
                flush = 1'b1;
                unique case (excepttype_i)
                    EXC_ERET: new_pc = cp0_epc_i;
                    EXC_INT, EXC_SYSCALL, EXC_INST_INVALID,
                    EXC_OV, EXC_TRAP: new_pc = EXC_VECTOR;
                    default: new_pc = EXC_VECTOR;
                endcase
            end else begin
                // deepest requesting stage wins
                priority case (1'b1)
                    stallreq_from_mem: stall = STALL_MEM;
                    stallreq_from_ex:  stall = STALL_EX;
                    stallreq_from_id:  stall = STALL_ID;
                    stallreq_from_if:  stall = STALL_IF;
                    default:           stall = STALL_NONE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_excepttype_o <= '0;
        end else if (flush) begin
            last_excepttype_o <= excepttype_i;
        end
    end

    stall_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .req_any (req_any),
        .clear   (flush),
        .timeout (stall_timeout_o)
    );

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_o <= '0;
            flush_count_o  <= '0;
        end else begin
            if (stall[0] && (stall_cycles_o != '1)) begin
                stall_cycles_o <= stall_cycles_o + 32'd1;
            end
            if (flush) begin
                flush_count_o <= flush_count_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: vector table, corner sequences and
// random stimulus against a run-length based reference model.
module tb_pipe_ctrl;

    localparam int T = 4;

    logic        clk;
    logic        rst;
    logic        stallreq_from_if;
    logic        stallreq_from_id;
    logic        stallreq_from_ex;
    logic        stallreq_from_mem;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout_o;
    logic [31:0] last_excepttype_o;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles_o;
    logic [15:0] flush_count_o;
`endif

    pipe_ctrl #(
        .TIMEOUT_CYCLES(T),
        .EXC_VECTOR(32'h0000_0020)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stallreq_from_if  (stallreq_from_if),
        .stallreq_from_id  (stallreq_from_id),
        .stallreq_from_ex  (stallreq_from_ex),
        .stallreq_from_mem (stallreq_from_mem),
        .excepttype_i      (excepttype_i),
        .cp0_epc_i         (cp0_epc_i),
        .stall             (stall),
        .flush             (flush),
        .new_pc            (new_pc),
        .stall_timeout_o   (stall_timeout_o),
`ifdef PIPE_PERF_CNT_EN
        .stall_cycles_o    (stall_cycles_o),
        .flush_count_o     (flush_count_o),
`endif
        .last_excepttype_o (last_excepttype_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    // reference model state
    int          run = 0;
    logic        m_to = 1'b0;
    logic [31:0] m_last = '0;
    logic [31:0] m_sc = '0;
    logic [15:0] m_fc = '0;

    typedef struct {
        logic        r;
        logic [3:0]  q;
        logic [31:0] exc;
        logic [31:0] epc;
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // q = {mem, ex, id, if}
    task automatic cycle(input logic r, input logic [3:0] q,
                         input logic [31:0] e, input logic [31:0] p,
                         output logic [5:0] a_stall, output logic a_flush,
                         output logic [31:0] a_pc);
        logic [5:0]  es;
        logic        ef;
        logic [31:0] ep;
        int          hi;
        rst = r;
        {stallreq_from_mem, stallreq_from_ex,
         stallreq_from_id, stallreq_from_if} = q;
        excepttype_i = e;
        cp0_epc_i = p;
        @(negedge clk);
        hi = 0;
        for (int i = 0; i < 4; i++) if (q[i]) hi = i + 1;
        ef = !r && (e != 0);
        es = (r || ef || hi == 0) ? 6'd0 : 6'((1 << (hi + 1)) - 1);
        ep = !ef ? 32'd0 : (e == 32'h0000_000e) ? p : 32'h0000_0020;
        a_stall = stall;
        a_flush = flush;
        a_pc = new_pc;
        if (stall_timeout_o === 1'b1) pulses++;
        chk("stall", 32'(stall), 32'(es));
        chk("flush", 32'(flush), 32'(ef));
        chk("new_pc", new_pc, ep);
        chk("timeout", 32'(stall_timeout_o), 32'(m_to));
        chk("last_exc", last_excepttype_o, m_last);
`ifdef PIPE_PERF_CNT_EN
        chk("stall_cycles", stall_cycles_o, m_sc);
        chk("flush_count", 32'(flush_count_o), 32'(m_fc));
`endif
        if (r) begin
            run = 0;
            m_to = 1'b0;
            m_last = '0;
            m_sc = '0;
            m_fc = '0;
        end else begin
            run = (q != 0 && !ef) ? run + 1 : 0;
            m_to = (run == T);
            if (ef) m_last = e;
            if (es[0] && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
            if (ef) m_fc = m_fc + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic r, input logic [3:0] q,
                        input logic [31:0] e, input logic [31:0] p);
        logic [5:0]  s;
        logic        f;
        logic [31:0] n;
        cycle(r, q, e, p, s, f, n);
    endtask

    initial begin
        logic [5:0]  s;
        logic        f;
        logic [31:0] n;
        logic [31:0] codes[8];
        logic [31:0] e;

        tbl[0]  = '{1'b1, 4'b1111, 32'h8,   32'h0,    6'b000000, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 4'b0010, 32'h0,   32'h0,    6'b000111, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 4'b1010, 32'h0,   32'h0,    6'b011111, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 4'b0001, 32'h0,   32'h0,    6'b000011, 1'b0, 32'h0};
        tbl[4]  = '{1'b0, 4'b0100, 32'h0,   32'h0,    6'b001111, 1'b0, 32'h0};
        tbl[5]  = '{1'b0, 4'b0111, 32'h0,   32'h0,    6'b001111, 1'b0, 32'h0};
        tbl[6]  = '{1'b0, 4'b0100, 32'h8,   32'h0,    6'b000000, 1'b1, 32'h20};
        tbl[7]  = '{1'b0, 4'b0000, 32'he,   32'h1234, 6'b000000, 1'b1, 32'h1234};
        tbl[8]  = '{1'b0, 4'b0000, 32'h1,   32'h1234, 6'b000000, 1'b1, 32'h20};
        tbl[9]  = '{1'b0, 4'b1111, 32'ha,   32'h0,    6'b000000, 1'b1, 32'h20};
        tbl[10] = '{1'b0, 4'b0000, 32'h100, 32'h0,    6'b000000, 1'b1, 32'h20};
        tbl[11] = '{1'b0, 4'b0000, 32'h0,   32'h0,    6'b000000, 1'b0, 32'h0};

        codes = '{32'h1, 32'h8, 32'ha, 32'hc, 32'hd, 32'he, 32'h55, 32'h8000_0000};

        rst = 1'b1;
        stallreq_from_if = 1'b0;
        stallreq_from_id = 1'b0;
        stallreq_from_ex = 1'b0;
        stallreq_from_mem = 1'b0;
        excepttype_i = '0;
        cp0_epc_i = '0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].r, tbl[i].q, tbl[i].exc, tbl[i].epc, s, f, n);
            chk($sformatf("tbl%0d_stall", i), 32'(s), 32'(tbl[i].stall));
            chk($sformatf("tbl%0d_flush", i), 32'(f), 32'(tbl[i].flush));
            chk($sformatf("tbl%0d_new_pc", i), n, tbl[i].pc);
        end

        // flush then last_excepttype follows on the next cycle
        step(1'b0, 4'b0100, 32'h8, 32'h0);
        step(1'b0, 4'b0000, 32'h0, 32'h0);
        chk("last_exc_after_syscall", last_excepttype_o, 32'h8);

        // watchdog: 10 stalled cycles give exactly one pulse, then restart
        pulses = 0;
        repeat (10) step(1'b0, 4'b0001, 32'h0, 32'h0);
        step(1'b0, 4'b0000, 32'h0, 32'h0);
        chk("wd_single_pulse", 32'(pulses), 32'd1);
        pulses = 0;
        repeat (3) step(1'b0, 4'b0001, 32'h0, 32'h0);
        step(1'b0, 4'b0000, 32'h0, 32'h0);
        chk("wd_restart_no_pulse", 32'(pulses), 32'd0);
        repeat (5) step(1'b0, 4'b0001, 32'h0, 32'h0);
        chk("wd_restart_pulse", 32'(pulses), 32'd1);
        step(1'b0, 4'b0000, 32'h0, 32'h0);

        // exception on the threshold cycle suppresses the pulse
        pulses = 0;
        repeat (3) step(1'b0, 4'b1000, 32'h0, 32'h0);
        step(1'b0, 4'b1000, 32'hc, 32'h0);
        repeat (2) step(1'b0, 4'b0000, 32'h0, 32'h0);
        chk("wd_flush_clears", 32'(pulses), 32'd0);

        // request dropping on the threshold cycle
        repeat (3) step(1'b0, 4'b0010, 32'h0, 32'h0);
        repeat (2) step(1'b0, 4'b0000, 32'h0, 32'h0);
        chk("wd_drop_clears", 32'(pulses), 32'd0);

        // reset mid-count
        repeat (3) step(1'b0, 4'b0001, 32'h0, 32'h0);
        step(1'b1, 4'b0001, 32'h0, 32'h0);
        repeat (3) step(1'b0, 4'b0001, 32'h0, 32'h0);
        step(1'b0, 4'b0000, 32'h0, 32'h0);
        chk("wd_reset_mid", 32'(pulses), 32'd0);

        // back-to-back exceptions
        step(1'b0, 4'b0000, 32'h8, 32'h0);
        step(1'b0, 4'b0001, 32'hc, 32'h0);
        step(1'b0, 4'b0000, 32'he, 32'h4444);
        step(1'b0, 4'b0000, 32'h0, 32'h0);
        chk("last_exc_b2b", last_excepttype_o, 32'he);

`ifdef PIPE_PERF_CNT_EN
        step(1'b1, 4'b0000, 32'h0, 32'h0);
        repeat (5) step(1'b0, 4'b0001, 32'h0, 32'h0);
        step(1'b0, 4'b0000, 32'h1, 32'h0);
        step(1'b0, 4'b0000, 32'hd, 32'h0);
        step(1'b0, 4'b0000, 32'h0, 32'h0);
        chk("perf_stall5", stall_cycles_o, 32'd5);
        chk("perf_flush2", 32'(flush_count_o), 32'd2);
        step(1'b1, 4'b0000, 32'h0, 32'h0);
        chk("perf_rst_stall", stall_cycles_o, 32'd0);
        chk("perf_rst_flush", 32'(flush_count_o), 32'd0);
`endif

        for (int k = 0; k < 400; k++) begin
            logic [3:0] q;
            q = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) q = 4'b0000;
            e = '0;
            if ($urandom_range(0, 9) == 0) e = codes[$urandom_range(0, 7)];
            step(($urandom_range(0, 59) == 0), q, e, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
